// File: rtl/pipeline_register_stage.sv
`default_nettype none
//==============================================================================
// Module      : pipeline_register_stage
// Description : Valid/ready register slice between the execute and write-back
//               stages. It carries a destination register index, a result
//               payload and a register-file write enable. Killed entries
//               (in_invalid) still take a slot and travel downstream as
//               bubbles with their write enable cleared.
//
//               Build option PIPE_REG_SKID_EN:
//                 defined   - head register plus one skid entry (capacity 2);
//                             in_ready comes straight from a flop
//                             (!skid valid), so there is no combinational
//                             path from out_ready to in_ready.
//                 undefined - a single head register (capacity 1);
//                             in_ready = !out_valid || out_ready.
//
// Ports       : clk        - clock, all state changes on the rising edge
//               rst        - asynchronous active-high reset
//               flush      - synchronous discard of every held entry
//               in_valid   - upstream presents an entry
//               in_ready   - this stage takes an entry this cycle
//               in_invalid - presented entry is killed (no register write)
//               in_rd      - destination register index  [RD_W]
//               in_data    - ALU result                  [DATA_W]
//               in_we      - register-file write enable
//               out_valid  - head entry is presented downstream
//               out_ready  - downstream takes the head entry
//               out_rd     - head destination index      [RD_W]
//               out_data   - head payload                [DATA_W]
//               out_we     - head write enable (0 whenever out_valid is 0)
//               occupancy  - number of held entries (0..2)
//
// Revision    : 1.0 - initial release
//==============================================================================
module pipeline_register_stage #(
    parameter int DATA_W = 32,
    parameter int RD_W   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_invalid,
    input  logic [RD_W-1:0]   in_rd,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_we,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [RD_W-1:0]   out_rd,
    output logic [DATA_W-1:0] out_data,
    output logic              out_we,
    output logic [1:0]        occupancy
);

    // Head entry: the one presented on out_*.
    logic              r_head_valid;
    logic              r_head_we;
    logic [RD_W-1:0]   r_head_rd;
    logic [DATA_W-1:0] r_head_data;

    logic w_push;      // entry accepted from upstream this cycle
    logic w_pop;       // head entry released downstream this cycle
    logic w_in_we;     // write enable as stored: killed entries never write

    assign w_push  = in_valid && in_ready;
    assign w_pop   = r_head_valid && out_ready;
    assign w_in_we = in_we && !in_invalid;

`ifdef PIPE_REG_SKID_EN
    // Skid entry: catches the one entry accepted while the head is stalled.
    logic              r_skid_valid;
    logic              r_skid_we;
    logic [RD_W-1:0]   r_skid_rd;
    logic [DATA_W-1:0] r_skid_data;

    // Registered ready: the skid slot being free is the only condition.
    assign in_ready = !r_skid_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head_valid <= 1'b0;
            r_head_we    <= 1'b0;
            r_head_rd    <= '0;
            r_head_data  <= '0;
            r_skid_valid <= 1'b0;
            r_skid_we    <= 1'b0;
            r_skid_rd    <= '0;
            r_skid_data  <= '0;
        end else if (flush) begin
            // Payloads keep their last values; only valid and we are cleared.
            r_head_valid <= 1'b0;
            r_head_we    <= 1'b0;
            r_skid_valid <= 1'b0;
            r_skid_we    <= 1'b0;
        end else if (w_pop || !r_head_valid) begin
            // Head is free next cycle: refill from skid first (older entry),
            // else from the input. The skid can only be full when the head
            // is full, and in_ready is low then, so no push coincides with
            // a skid promotion.
            if (r_skid_valid) begin
                r_head_valid <= 1'b1;
                r_head_we    <= r_skid_we;
                r_head_rd    <= r_skid_rd;
                r_head_data  <= r_skid_data;
                r_skid_valid <= 1'b0;
                r_skid_we    <= 1'b0;
            end else if (w_push) begin
                r_head_valid <= 1'b1;
                r_head_we    <= w_in_we;
                r_head_rd    <= in_rd;
                r_head_data  <= in_data;
            end else begin
                r_head_valid <= 1'b0;
                r_head_we    <= 1'b0;
            end
        end else if (w_push) begin
            // Head stalled: park the new entry in the skid slot.
            r_skid_valid <= 1'b1;
            r_skid_we    <= w_in_we;
            r_skid_rd    <= in_rd;
            r_skid_data  <= in_data;
        end
    end

    assign occupancy = {1'b0, r_head_valid} + {1'b0, r_skid_valid};
`else
    // Single slot: accept when empty or when the head leaves this cycle.
    assign in_ready = !r_head_valid || out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head_valid <= 1'b0;
            r_head_we    <= 1'b0;
            r_head_rd    <= '0;
            r_head_data  <= '0;
        end else if (flush) begin
            r_head_valid <= 1'b0;
            r_head_we    <= 1'b0;
        end else if (w_push) begin
            r_head_valid <= 1'b1;
            r_head_we    <= w_in_we;
            r_head_rd    <= in_rd;
            r_head_data  <= in_data;
        end else if (w_pop) begin
            r_head_valid <= 1'b0;
            r_head_we    <= 1'b0;
        end
    end

    assign occupancy = {1'b0, r_head_valid};
`endif

    assign out_valid = r_head_valid;
    assign out_rd    = r_head_rd;
    assign out_data  = r_head_data;
    assign out_we    = r_head_valid && r_head_we;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_register_stage.sv
`default_nettype none
//==============================================================================
// Module      : tb_pipeline_register_stage
// Description : Self-checking bench for pipeline_register_stage. Accepted
//               entries are pushed into an expected queue; a monitor pops and
//               compares every entry released downstream. Directed checks
//               cover reset state, latency, kill, backpressure, flush and
//               asynchronous reset. Follows PIPE_REG_SKID_EN like the design.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_pipeline_register_stage;

    localparam int DATA_W = 32;
    localparam int RD_W   = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic              in_invalid;
    logic [RD_W-1:0]   in_rd;
    logic [DATA_W-1:0] in_data;
    logic              in_we;
    logic              out_valid;
    logic              out_ready;
    logic [RD_W-1:0]   out_rd;
    logic [DATA_W-1:0] out_data;
    logic              out_we;
    logic [1:0]        occupancy;

    pipeline_register_stage #(.DATA_W(DATA_W), .RD_W(RD_W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_invalid(in_invalid),
        .in_rd(in_rd), .in_data(in_data), .in_we(in_we),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_rd(out_rd), .out_data(out_data), .out_we(out_we),
        .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [RD_W-1:0]   rd;
        logic [DATA_W-1:0] data;
        logic              we;
    } entry_t;

    entry_t exp_q[$];
    int     n_checks = 0;
    int     n_pass   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Scoreboard: release compared first, then this cycle's acceptance queued.
    always @(negedge clk) begin
        entry_t got, e;
        if (!rst) begin
            if (out_valid && out_ready) begin
                got = '{rd: out_rd, data: out_data, we: out_we};
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_out: got rd=%0h data=0x%0h we=%0b expected nothing",
                             out_rd, out_data, out_we);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_entry", {27'd0, got}, {27'd0, e});
                end
            end
            if (flush) exp_q.delete();
            else if (in_valid && in_ready)
                exp_q.push_back('{rd: in_rd, data: in_data, we: in_we && !in_invalid});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [RD_W-1:0] rd,
                         input logic [DATA_W-1:0] d, input logic we, input logic kill);
        in_valid   = v;
        in_rd      = rd;
        in_data    = d;
        in_we      = we;
        in_invalid = kill;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        tick(); tick();
        // Reset state while rst is high
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_we",    out_we,    0);
        chk("rst_out_rd",    out_rd,    0);
        chk("rst_out_data",  out_data,  0);
        chk("rst_occupancy", occupancy, 0);
        rst = 1'b0;
        tick();
        chk("ready_after_rst", in_ready, 1);

        // Stream of 8 with out_ready held high
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, RD_W'(i), DATA_W'(i), 1'b1, 1'b0);
            tick();
            chk("stream_valid", out_valid, 1);
            chk("stream_data",  out_data,  i);
            chk("stream_occ",   occupancy, 1);
        end
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        tick();
        chk("stream_drain_occ", occupancy, 0);

        // Killed entry
        out_ready = 1'b0;
        drive(1'b1, 4'd5, 32'hDEAD, 1'b1, 1'b1);
        tick();
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        chk("kill_valid", out_valid, 1);
        chk("kill_rd",    out_rd,    5);
        chk("kill_data",  out_data,  32'hDEAD);
        chk("kill_we",    out_we,    0);
        out_ready = 1'b1;
        tick();
        chk("kill_drain_occ", occupancy, 0);

        // Backpressure
        out_ready = 1'b0;
        drive(1'b1, 4'd1, 32'h11, 1'b1, 1'b0);
        tick();
`ifdef PIPE_REG_SKID_EN
        chk("bp_occ_a",   occupancy, 1);
        chk("bp_ready_a", in_ready,  1);
        drive(1'b1, 4'd2, 32'h22, 1'b1, 1'b0);
        tick();
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        chk("bp_occ_ab",   occupancy, 2);
        chk("bp_ready_ab", in_ready,  0);
        chk("bp_hold_a",   out_data,  32'h11);
        tick();
        chk("bp_still_a",  out_data,  32'h11);
        out_ready = 1'b1;
        tick();
        chk("bp_head_b",   out_data,  32'h22);
        chk("bp_ready_b",  in_ready,  1);
        tick();
        chk("bp_drain_occ", occupancy, 0);
`else
        chk("bp_occ_a",   occupancy, 1);
        chk("bp_ready_a", in_ready,  0);
        drive(1'b1, 4'd2, 32'h22, 1'b1, 1'b0);
        tick();
        chk("bp_hold_a",  out_data,  32'h11);
        chk("bp_occ_1",   occupancy, 1);
        tick();
        chk("bp_still_a", out_data,  32'h11);
        out_ready = 1'b1;
        #1;
        chk("bp_ready_comb", in_ready, 1);
        tick();
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        chk("bp_head_b",  out_data,  32'h22);
        chk("bp_occ_b",   occupancy, 1);
        tick();
        chk("bp_drain_occ", occupancy, 0);
`endif

        // Flush with a same-cycle presented entry
        out_ready = 1'b0;
        drive(1'b1, 4'd1, 32'h11, 1'b1, 1'b0);
        tick();
`ifdef PIPE_REG_SKID_EN
        drive(1'b1, 4'd2, 32'h22, 1'b1, 1'b0);
        tick();
        chk("flush_pre_occ", occupancy, 2);
`else
        chk("flush_pre_occ", occupancy, 1);
`endif
        drive(1'b1, 4'd3, 32'h33, 1'b1, 1'b0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        chk("flush_valid",  out_valid, 0);
        chk("flush_occ",    occupancy, 0);
        chk("flush_we",     out_we,    0);
        chk("flush_retain", out_data,  32'h11);
        out_ready = 1'b1;
        tick(); tick();
        chk("flush_no_emit", out_valid, 0);

        // Asynchronous reset between edges with one entry held
        out_ready = 1'b0;
        drive(1'b1, 4'd4, 32'h44, 1'b1, 1'b0);
        tick();
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        chk("arst_pre_occ", occupancy, 1);
        #2;
        rst = 1'b1;
        #1;
        exp_q.delete();
        chk("arst_valid", out_valid, 0);
        chk("arst_we",    out_we,    0);
        chk("arst_occ",   occupancy, 0);
        chk("arst_data",  out_data,  0);
        tick();
        rst = 1'b0;
        tick();
        chk("arst_ready", in_ready,  1);
        chk("arst_empty", out_valid, 0);
        out_ready = 1'b1;
        drive(1'b1, 4'd6, 32'h55, 1'b1, 1'b0);
        tick();
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        chk("post_arst_data", out_data, 32'h55);
        tick(); tick();

        chk("queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
